multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle RISC-V core; successor to the single-cycle main decoder. It sequences fetch, decode, execute, memory and writeback over several cycles and adds a memory-ready wait handshake. It drives the datapath mux selects and write strobes. The ALU decoder stays a separate block fed by alu_op.

Parameters:
MEM_WAIT, 1, 1 = honour mem_ready (insert wait states); 0 = treat mem_ready as constant 1
ALU_OP_W, 2, width of alu_op to the ALU decoder
IMM_SRC_W, 3, width of imm_src

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  7  opcode from instruction register; valid from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  unified memory has completed the current access this cycle
mem_req  out  1  memory access request
mem_write  out  1  store strobe, qualified by mem_ready
ir_write  out  1  load instruction register
adr_src  out  1  0 = PC, 1 = alu_out
pc_write  out  1  PC enable = pc_update | (branch & zero)
reg_write  out  1  register file write
alu_src_a  out  2  00 PC, 01 old_pc, 10 rd1
alu_src_b  out  2  00 rd2, 01 imm_ext, 10 const 4
result_src  out  2  00 alu_out, 01 data, 10 alu_result, 11 imm_ext
alu_op  out  ALU_OP_W  00 add, 01 sub (branch), 10 funct-decoded
imm_src  out  IMM_SRC_W  combinational from op: lw/I 000, sw 001, beq 010, jal 011, lui 100, others xxx
instr_done  out  1  one-cycle pulse on the final cycle of each instruction

Behaviour:
- One clock. Reset is asynchronous and active-low: rst_n low forces state = FETCH, and all strobes (mem_req, mem_write, ir_write, pc_write, reg_write, instr_done) are 0 while rst_n is low. Selects are 0.
- All outputs are decoded from the current state (Moore), except imm_src (decoded from op) and pc_write (uses zero).
- Any strobe that is not listed for a state is 0. Any select that is not listed is 00.
- FETCH: mem_req=1, adr_src=0, alu_src_b=10, result_src=10, alu_op=00. ir_write and pc_update equal mem_ready. Hold in FETCH until mem_ready, then go to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch/jump target into alu_out). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BEQ
  - 0110111 → LUI
  - other → ILLEGAL handling (see Optional Feature)
- MEMADR: alu_src_a=10, alu_src_b=01. Next is MEMREAD if op=lw, else MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Wait for mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Next is FETCH.
- MEMWRITE: mem_req=1, adr_src=1, mem_write=mem_ready. Wait for mem_ready, then FETCH with instr_done=1 on the ready cycle.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Next is ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10. Next is ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1. Next is FETCH.
- JAL: alu_src_a=01, alu_src_b=10, pc_update=1. Next is ALUWB, which writes rd = old_pc + 4.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, branch=1, result_src=00, instr_done=1. Next is FETCH.
- LUI: result_src=11, reg_write=1, instr_done=1. Next is FETCH.
- Latency with MEM_WAIT=0 or zero-wait memory: lw 5 cycles; sw 4; R/I 4; jal 4; beq 3; lui 3.
- Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle. No strobe other than mem_req is asserted during a wait cycle.
- mem_ready is ignored outside the three memory states.
- rst_n asserted mid-instruction: immediate return to FETCH. No partial write-back occurs after the reset edge.

Optional Feature:
CTRL_ILLEGAL_TRAP_EN
- Defined: an unknown op in DECODE moves to TRAP. TRAP holds forever with all strobes 0 and output illegal_instr=1 (extra 1-bit port). Only rst_n exits TRAP.
- Undefined: an unknown op is a NOP. DECODE goes to FETCH with instr_done=1, and the illegal_instr port is absent.

Decomposition:
- Package ctrl_pkg holds:
  - state enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ, LUI, TRAP
  - opcode localparams
  - src/result/alu_op encoding constants
- One natural sub-module: imm_src_dec, a combinational op → imm_src table shared with the single-cycle core.

Test Plan:
- Reset: rst_n=0 mid-MEMREAD → state FETCH immediately; all strobes 0; after release, mem_req=1 next cycle.
- lw, MEM_WAIT=1, mem_ready low 2 cycles in FETCH and 1 cycle in MEMREAD → 8 total cycles; ir_write exactly once; reg_write once with result_src=01; instr_done one pulse.
- beq (op=1100011): zero=1 → pc_write=1 in the BEQ cycle, alu_op=01. zero=0 → pc_write=0. 3 cycles each.
- sw, mem_ready tied 1 → mem_write=1 for exactly one cycle with adr_src=1; reg_write never asserted; 4 cycles.
- Back-to-back jal, R-type, lui → jal: pc_write in JAL, reg_write in ALUWB. R-type: alu_op=10, alu_src_b=00. lui: result_src=11, imm_src=100. instr_done pulses at cycles 4, 8, 11.
- op=1111111 → with CTRL_ILLEGAL_TRAP_EN: illegal_instr=1 held, no strobes. Without: returns to FETCH after 2 cycles, instr_done=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - state, opcode and datapath select encodings for multicycle_ctrl
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, JAL, BEQ, LUI, TRAP
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RD1    = 2'b10;

    localparam logic [1:0] SRC_B_RD2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALU_OUT    = 2'b00;
    localparam logic [1:0] RES_DATA       = 2'b01;
    localparam logic [1:0] RES_ALU_RESULT = 2'b10;
    localparam logic [1:0] RES_IMM        = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - unified memory request/ready handshake between controller and memory
// master (controller): drives mem_req, mem_write; samples mem_ready
// slave  (memory)    : samples mem_req, mem_write; drives mem_ready
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_write;
    logic mem_ready;

    modport master (output mem_req, output mem_write, input mem_ready);
    modport slave  (input mem_req, input mem_write, output mem_ready);
endinterface

// File: rtl/imm_src_dec.sv
// rtl/imm_src_dec.sv - combinational opcode to immediate-format select table
// in  op[6:0]            opcode
// out imm_src[IMM_SRC_W] immediate format select (lw/I 000, sw 001, beq 010, jal 011, lui 100)
module imm_src_dec import ctrl_pkg::*; #(
    parameter int IMM_SRC_W = 3
) (
    input  logic [6:0]           op,
    output logic [IMM_SRC_W-1:0] imm_src
);
    logic [2:0] sel;

    // Opcodes without an immediate fall through to the I format; nothing consumes it.
    always_comb begin
        sel = IMM_I;
        case (op)
            OP_SW:   sel = IMM_S;
            OP_BEQ:  sel = IMM_B;
            OP_JAL:  sel = IMM_J;
            OP_LUI:  sel = IMM_U;
            default: sel = IMM_I;
        endcase
    end

    assign imm_src = IMM_SRC_W'(sel);
endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM of the multicycle RISC-V core with memory-ready waits
// in  clk, rst_n (async, active low), op[6:0], zero
// io  mem (multicycle_ctrl_if.master): mem_req, mem_write out; mem_ready in
// out ir_write, adr_src, pc_write, reg_write, alu_src_a[2], alu_src_b[2], result_src[2],
//     alu_op[ALU_OP_W], imm_src[IMM_SRC_W], instr_done
// out illegal_instr (only when CTRL_ILLEGAL_TRAP_EN is defined)
module multicycle_ctrl import ctrl_pkg::*; #(
    parameter bit MEM_WAIT  = 1'b1,
    parameter int ALU_OP_W  = 2,
    parameter int IMM_SRC_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           op,
    input  logic                 zero,
    multicycle_ctrl_if.master    mem,
    output logic                 ir_write,
    output logic                 adr_src,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           result_src,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic [IMM_SRC_W-1:0] imm_src,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic                 illegal_instr,
`endif
    output logic                 instr_done
);
    state_t state, state_nxt;

    logic rdy;
    logic pc_update, branch;
    logic mem_req_c, mem_write_c, ir_write_c, adr_src_c, reg_write_c, done_c;
    logic [1:0] src_a_c, src_b_c, res_c, alu_op_c;
    logic [IMM_SRC_W-1:0] imm_src_raw;

    // Without wait support the memory is assumed to complete every access in one cycle.
    assign rdy = MEM_WAIT ? mem.mem_ready : 1'b1;

    imm_src_dec #(.IMM_SRC_W(IMM_SRC_W)) u_imm_src_dec (
        .op      (op),
        .imm_src (imm_src_raw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        mem_req_c   = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        adr_src_c   = 1'b0;
        reg_write_c = 1'b0;
        done_c      = 1'b0;
        pc_update   = 1'b0;
        branch      = 1'b0;
        src_a_c     = SRC_A_PC;
        src_b_c     = SRC_B_RD2;
        res_c       = RES_ALU_OUT;
        alu_op_c    = ALU_ADD;
        case (state)
            FETCH: begin
                mem_req_c  = 1'b1;
                src_b_c    = SRC_B_FOUR;
                res_c      = RES_ALU_RESULT;
                ir_write_c = rdy;
                pc_update  = rdy;
                if (rdy) state_nxt = DECODE;
            end
            DECODE: begin
                // Branch/jump target is computed here so it sits in alu_out for later states.
                src_a_c = SRC_A_OLD_PC;
                src_b_c = SRC_B_IMM;
                case (op)
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_R:         state_nxt = EXECR;
                    OP_I:         state_nxt = EXECI;
                    OP_JAL:       state_nxt = JAL;
                    OP_BEQ:       state_nxt = BEQ;
                    OP_LUI:       state_nxt = LUI;
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_nxt = TRAP;
`else
                        state_nxt = FETCH;
                        done_c    = 1'b1;
`endif
                    end
                endcase
            end
            MEMADR: begin
                src_a_c   = SRC_A_RD1;
                src_b_c   = SRC_B_IMM;
                state_nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                if (rdy) state_nxt = MEMWB;
            end
            MEMWB: begin
                res_c       = RES_DATA;
                reg_write_c = 1'b1;
                done_c      = 1'b1;
                state_nxt   = FETCH;
            end
            MEMWRITE: begin
                mem_req_c   = 1'b1;
                adr_src_c   = 1'b1;
                mem_write_c = rdy;
                done_c      = rdy;
                if (rdy) state_nxt = FETCH;
            end
            EXECR: begin
                src_a_c   = SRC_A_RD1;
                src_b_c   = SRC_B_RD2;
                alu_op_c  = ALU_FUNCT;
                state_nxt = ALUWB;
            end
            EXECI: begin
                src_a_c   = SRC_A_RD1;
                src_b_c   = SRC_B_IMM;
                alu_op_c  = ALU_FUNCT;
                state_nxt = ALUWB;
            end
            ALUWB: begin
                res_c       = RES_ALU_OUT;
                reg_write_c = 1'b1;
                done_c      = 1'b1;
                state_nxt   = FETCH;
            end
            JAL: begin
                // PC takes the target from alu_out while the ALU forms old_pc + 4 for rd.
                src_a_c   = SRC_A_OLD_PC;
                src_b_c   = SRC_B_FOUR;
                pc_update = 1'b1;
                state_nxt = ALUWB;
            end
            BEQ: begin
                src_a_c   = SRC_A_RD1;
                src_b_c   = SRC_B_RD2;
                alu_op_c  = ALU_SUB;
                branch    = 1'b1;
                res_c     = RES_ALU_OUT;
                done_c    = 1'b1;
                state_nxt = FETCH;
            end
            LUI: begin
                res_c       = RES_IMM;
                reg_write_c = 1'b1;
                done_c      = 1'b1;
                state_nxt   = FETCH;
            end
            TRAP:    state_nxt = TRAP;
            default: state_nxt = FETCH;
        endcase
    end

    // While rst_n is low every output is forced to zero, independent of the clock.
    assign mem.mem_req   = rst_n & mem_req_c;
    assign mem.mem_write = rst_n & mem_write_c;
    assign ir_write      = rst_n & ir_write_c;
    assign adr_src       = rst_n & adr_src_c;
    assign pc_write      = rst_n & (pc_update | (branch & zero));
    assign reg_write     = rst_n & reg_write_c;
    assign instr_done    = rst_n & done_c;
    assign alu_src_a     = rst_n ? src_a_c : 2'b00;
    assign alu_src_b     = rst_n ? src_b_c : 2'b00;
    assign result_src    = rst_n ? res_c : 2'b00;
    assign alu_op        = rst_n ? ALU_OP_W'(alu_op_c) : '0;
    assign imm_src       = rst_n ? imm_src_raw : '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal_instr = rst_n & (state == TRAP);
`endif
endmodule
